jt51_wr_sched: RTL

- CPU-side write scheduler for the JT51 operator/channel register file.
- Latches YM2151-style address/data writes and queues them in a small FIFO.
- Decodes each entry into the register file's update strobes plus op/ch select, then holds them through one full 32-slot busy pass.
- Routes global registers (addr < 0x20, except 0x08) to a separate one-cycle global write port, in queue order.

---
 rtl/jt51_wr_sched.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/jt51_wr_sched.sv
// CPU write scheduler for the JT51 register file: queues address/data writes and
// replays each one as a strobe held for a full busy pass, or as a global port write.
module jt51_wr_sched #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_wr,
  input  logic       a0,
  input  logic [7:0] din,
  input  logic       clr_ovf,
  input  logic       reg_busy,
  output logic [7:0] d_out,
  output logic [1:0] op,
  output logic [2:0] ch,
  output logic       up_rl,
  output logic       up_kc,
  output logic       up_kf,
  output logic       up_pms,
  output logic       up_dt1,
  output logic       up_tl,
  output logic       up_ks,
  output logic       up_amsen,
  output logic       up_dt2,
  output logic       up_d1l,
  output logic       up_keyon,
  output logic       glb_wr,
  output logic [7:0] glb_addr,
  output logic [7:0] glb_data,
  output logic       busy_out,
  output logic       ovf
);

  localparam int S_KEYON = 0;
  localparam int S_RL    = 1;
  localparam int S_DT1   = 5;

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW-1:0] PTR_ONE  = 1;

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD, POP} state_t;

  state_t      state, state_nxt;
  logic [7:0]  addr_latch;
  logic [15:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;

  logic        full, pop, push_req, push_ok, drop;
  logic [7:0]  head_addr, head_data;

  logic [10:0] strb, strb_nxt, dec_strb;
  logic [1:0]  dec_op, op_nxt;
  logic [2:0]  dec_ch, ch_nxt;
  logic        dec_glb;
  logic [7:0]  d_nxt, glb_addr_nxt, glb_data_nxt;
  logic        glb_wr_nxt;

  assign full      = (count == FULL_CNT);
  assign pop       = (state == POP);
  assign push_req  = cpu_wr & a0;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push
  assign push_ok   = push_req & (~full | pop);
  assign drop      = push_req & full & ~pop;
  assign head_addr = mem[rd_ptr][15:8];
  assign head_data = mem[rd_ptr][7:0];
  assign busy_out  = (count != '0) | (state != IDLE);

  assign up_keyon = strb[0];
  assign up_rl    = strb[1];
  assign up_kc    = strb[2];
  assign up_kf    = strb[3];
  assign up_pms   = strb[4];
  assign up_dt1   = strb[5];
  assign up_tl    = strb[6];
  assign up_ks    = strb[7];
  assign up_amsen = strb[8];
  assign up_dt2   = strb[9];
  assign up_d1l   = strb[10];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {addr_latch, din};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_latch <= 8'h00;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      ovf        <= 1'b0;
    end else begin
      if (cpu_wr && !a0) addr_latch <= din;
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (drop)         ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
    end
  end

  always_comb begin
    dec_strb = '0;
    dec_op   = '0;
    dec_ch   = '0;
    dec_glb  = 1'b0;
    if (head_addr == 8'h08) begin
      dec_strb[S_KEYON] = 1'b1;
    end else if (head_addr < 8'h20) begin
      dec_glb = 1'b1;
    end else if (head_addr < 8'h40) begin
      dec_strb[S_RL + int'(head_addr[4:3])] = 1'b1;
      dec_ch = head_addr[2:0];
    end else begin
      // 0x40..0xFF: bits 7:5 pick the parameter, 4:3 the operator
      dec_strb[S_DT1 + int'(head_addr[7:5]) - 2] = 1'b1;
      dec_op = head_addr[4:3];
      dec_ch = head_addr[2:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      strb     <= '0;
      d_out    <= 8'h00;
      op       <= 2'd0;
      ch       <= 3'd0;
      glb_wr   <= 1'b0;
      glb_addr <= 8'h00;
      glb_data <= 8'h00;
    end else begin
      state    <= state_nxt;
      strb     <= strb_nxt;
      d_out    <= d_nxt;
      op       <= op_nxt;
      ch       <= ch_nxt;
      glb_wr   <= glb_wr_nxt;
      glb_addr <= glb_addr_nxt;
      glb_data <= glb_data_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    strb_nxt     = strb;
    d_nxt        = d_out;
    op_nxt       = op;
    ch_nxt       = ch;
    glb_wr_nxt   = 1'b0;
    glb_addr_nxt = glb_addr;
    glb_data_nxt = glb_data;
    case (state)
      IDLE: begin
        if (count != '0) begin
          if (dec_glb) begin
            glb_wr_nxt   = 1'b1;
            glb_addr_nxt = head_addr;
            glb_data_nxt = head_data;
            state_nxt    = POP;
          end else begin
            strb_nxt  = dec_strb;
            d_nxt     = head_data;
            op_nxt    = dec_op;
            ch_nxt    = dec_ch;
            state_nxt = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (reg_busy) state_nxt = HOLD;
      end
      HOLD: begin
        // Dropping on the busy fall keeps the write from landing in a second pass
        if (!reg_busy) begin
          strb_nxt  = '0;
          state_nxt = POP;
        end
      end
      POP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
